// File: rtl/sap_sequencer.sv
// sap_sequencer: parametrised T-state ring and control-word decoder for the SAP CPU.
// Optional early termination of short instructions is enabled by defining SAP_SEQ_EARLY_END_EN.
module sap_sequencer #(
   parameter int CW_WIDTH     = 12,
   parameter int OPCODE_WIDTH = 4,
   parameter int NUM_T        = 6
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    run,
   input  logic [OPCODE_WIDTH-1:0] instruction,
   output logic [CW_WIDTH-1:0]     control_word,
   output logic [NUM_T-1:0]        t_state,
   output logic                    halted,
   output logic                    instr_done
);

   localparam int OP_W = (OPCODE_WIDTH > 4) ? OPCODE_WIDTH : 4;

   localparam logic [11:0] CW_NOP     = 12'h3E3;
   localparam logic [11:0] CW_T1      = 12'h5E3;
   localparam logic [11:0] CW_T2      = 12'hBE3;
   localparam logic [11:0] CW_T3      = 12'h263;
   localparam logic [11:0] CW_T4_MEM  = 12'h1A3;
   localparam logic [11:0] CW_T4_OUT  = 12'h3F2;
   localparam logic [11:0] CW_T5_LDA  = 12'h2C3;
   localparam logic [11:0] CW_T5_ALU  = 12'h2E1;
   localparam logic [11:0] CW_T6_ADD  = 12'h3C7;
   localparam logic [11:0] CW_T6_SUB  = 12'h3CF;

   logic [NUM_T-1:0] ring_r;
   logic [NUM_T-1:0] ring_next_s;
   logic             halted_r;
   logic             halted_next_s;
   logic [OP_W-1:0]  op_s;
   logic             is_lda_s;
   logic             is_add_s;
   logic             is_sub_s;
   logic             is_out_s;
   logic             is_halt_s;
   logic             active_s;
   logic             last_s;
   logic [11:0]      cw_s;

   // Zero-extend so narrow or wide opcode fields compare against the fixed opcode values
   assign op_s      = OP_W'(instruction);
   assign is_lda_s  = (op_s == OP_W'(4'd0));
   assign is_add_s  = (op_s == OP_W'(4'd1));
   assign is_sub_s  = (op_s == OP_W'(4'd2));
   assign is_out_s  = (op_s == OP_W'(4'd14));
   assign is_halt_s = (op_s == OP_W'(4'd15));

   // Stalled, halted or in reset: nothing may be loaded this cycle
   assign active_s = reset_n & run & ~halted_r;

   // Last T-state of the current instruction
   always_comb begin
      last_s = ring_r[NUM_T-1];
`ifdef SAP_SEQ_EARLY_END_EN
      if (ring_r[3] && !is_halt_s && !is_lda_s && !is_add_s && !is_sub_s) begin
         last_s = 1'b1;
      end else if (ring_r[4] && is_lda_s) begin
         last_s = 1'b1;
      end else if (ring_r[5] && (is_add_s || is_sub_s)) begin
         last_s = 1'b1;
      end else begin
         last_s = ring_r[NUM_T-1];
      end
`endif
   end

   // Control word decode from T-state and opcode (opcode ignored before T4)
   always_comb begin
      cw_s = CW_NOP;
      if (!active_s) begin
         cw_s = CW_NOP;
      end else if (ring_r[0]) begin
         cw_s = CW_T1;
      end else if (ring_r[1]) begin
         cw_s = CW_T2;
      end else if (ring_r[2]) begin
         cw_s = CW_T3;
      end else if (ring_r[3]) begin
         if (is_lda_s || is_add_s || is_sub_s) begin
            cw_s = CW_T4_MEM;
         end else if (is_out_s) begin
            cw_s = CW_T4_OUT;
         end else begin
            cw_s = CW_NOP;
         end
      end else if (ring_r[4]) begin
         if (is_lda_s) begin
            cw_s = CW_T5_LDA;
         end else if (is_add_s || is_sub_s) begin
            cw_s = CW_T5_ALU;
         end else begin
            cw_s = CW_NOP;
         end
      end else if (ring_r[5]) begin
         if (is_add_s) begin
            cw_s = CW_T6_ADD;
         end else if (is_sub_s) begin
            cw_s = CW_T6_SUB;
         end else begin
            cw_s = CW_NOP;
         end
      end else begin
         cw_s = CW_NOP;
      end
   end

   // Next ring position and sticky halt
   always_comb begin
      ring_next_s   = ring_r;
      halted_next_s = halted_r;
      if (active_s) begin
         if (ring_r[3] && is_halt_s) begin
            halted_next_s = 1'b1;
         end else if (last_s) begin
            ring_next_s = NUM_T'(1'b1);
         end else begin
            ring_next_s = {ring_r[NUM_T-2:0], ring_r[NUM_T-1]};
         end
      end else begin
         ring_next_s   = ring_r;
         halted_next_s = halted_r;
      end
   end

   // State register with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ring_r   <= NUM_T'(1'b1);
         halted_r <= 1'b0;
      end else begin
         ring_r   <= ring_next_s;
         halted_r <= halted_next_s;
      end
   end

   assign control_word = CW_WIDTH'(cw_s);
   assign t_state      = ring_r;
   assign halted       = halted_r;
   assign instr_done   = active_s & last_s;

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: a 6-state and an 8-state instance run side by side
// against a table-driven reference model of instruction lengths and per-T-state control words.
module tb_sap_sequencer;

`ifdef SAP_SEQ_EARLY_END_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [11:0] NOP = 12'h3E3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        run;
   logic [3:0]  instruction;
   logic [11:0] cw6;
   logic [5:0]  ts6;
   logic        h6;
   logic        d6;
   logic [15:0] cw8;
   logic [7:0]  ts8;
   logic        h8;
   logic        d8;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   int t6 = 1;
   int t8 = 1;
   bit hl6 = 1'b0;
   bit hl8 = 1'b0;

   always #5 clock = ~clock;

   sap_sequencer dut6 (
      .clock(clock), .reset_n(reset_n), .run(run), .instruction(instruction),
      .control_word(cw6), .t_state(ts6), .halted(h6), .instr_done(d6)
   );

   sap_sequencer #(.CW_WIDTH(16), .OPCODE_WIDTH(4), .NUM_T(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .run(run), .instruction(instruction),
      .control_word(cw8), .t_state(ts8), .halted(h8), .instr_done(d8)
   );

   // Control word the SAP microprogram requires in T-state t for opcode op
   function automatic logic [11:0] exp_word(int t, int op, bit active);
      if (!active) return NOP;
      case (t)
         1: return 12'h5E3;
         2: return 12'hBE3;
         3: return 12'h263;
         4: return (op <= 2) ? 12'h1A3 : (op == 14) ? 12'h3F2 : NOP;
         5: return (op == 0) ? 12'h2C3 : (op == 1 || op == 2) ? 12'h2E1 : NOP;
         6: return (op == 1) ? 12'h3C7 : (op == 2) ? 12'h3CF : NOP;
         default: return NOP;
      endcase
   endfunction

   function automatic bit exp_done(int t, int nt, int op, bit active);
      int len;
      if (!active) return 1'b0;
      if (t == nt) return 1'b1;
      if (!EARLY || op == 15) return 1'b0;
      len = (op == 0) ? 5 : (op == 1 || op == 2) ? 6 : 4;
      return (t == len);
   endfunction

   function automatic int next_t(int t, bit h, int nt, int op, bit r);
      if (!r || h) return t;
      if (t == 4 && op == 15) return t;
      if (exp_done(t, nt, op, 1'b1)) return 1;
      return t + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h (t6=%0d t8=%0d op=%0d run=%0b)",
                tag, obs, expv, t6, t8, instruction, run);
      end
   endtask

   task automatic check_all();
      bit a6;
      bit a8;
      a6 = reset_n && run && !hl6;
      a8 = reset_n && run && !hl8;
      chk("cw6",   32'(cw6), 32'(exp_word(t6, int'(instruction), a6)));
      chk("ts6",   32'(ts6), 32'(1) << (t6 - 1));
      chk("halt6", 32'(h6),  32'(hl6));
      chk("done6", 32'(d6),  32'(exp_done(t6, 6, int'(instruction), a6)));
      chk("cw8",   32'(cw8), {20'h0, exp_word(t8, int'(instruction), a8)});
      chk("ts8",   32'(ts8), 32'(1) << (t8 - 1));
      chk("halt8", 32'(h8),  32'(hl8));
      chk("done8", 32'(d8),  32'(exp_done(t8, 8, int'(instruction), a8)));
   endtask

   task automatic reset_model();
      t6 = 1; t8 = 1; hl6 = 1'b0; hl8 = 1'b0;
   endtask

   // Drive one cycle's inputs, check mid-cycle, then advance the model across the edge
   task automatic step(input bit r, input logic [3:0] op);
      bit nh6;
      bit nh8;
      run = r;
      instruction = op;
      #2;
      check_all();
      @(posedge clock);
      if (!reset_n) begin
         reset_model();
      end else begin
         nh6 = hl6 | (r && !hl6 && t6 == 4 && op == 4'd15);
         nh8 = hl8 | (r && !hl8 && t8 == 4 && op == 4'd15);
         t6  = next_t(t6, hl6, 6, int'(op), r);
         t8  = next_t(t8, hl8, 8, int'(op), r);
         hl6 = nh6;
         hl8 = nh8;
      end
      #1;
   endtask

   function automatic logic [3:0] pick_op();
      case ($urandom_range(0, 4))
         0: return 4'd0;
         1: return 4'd1;
         2: return 4'd2;
         3: return 4'd14;
         default: return 4'($urandom_range(3, 13));
      endcase
   endfunction

   initial begin
      logic [3:0] op;
      reset_n = 1'b0;
      run = 1'b1;
      instruction = 4'd0;
      @(posedge clock);
      #1;
      step(1'b1, 4'd0);
      step(1'b1, 4'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) step(1'b1, 4'd0);
      for (int i = 0; i < 14; i++) step(1'b1, 4'd2);
      for (int i = 0; i < 14; i++) step(1'b1, 4'd14);
      for (int i = 0; i < 14; i++) step(1'b1, 4'd1);

      // Stall ADD in T5 for three cycles
      for (int i = 0; i < 20 && t6 != 5; i++) step(1'b1, 4'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 4'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 4'd1);

      // Asynchronous reset in the middle of LDA's T5
      for (int i = 0; i < 20 && t6 != 5; i++) step(1'b1, 4'd0);
      run = 1'b1;
      instruction = 4'd0;
      #1;
      reset_n = 1'b0;
      reset_model();
      #1;
      check_all();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, 4'd0);

      // Randomised mix of opcodes and stalls
      op = 4'd0;
      for (int i = 0; i < 400; i++) begin
         if (t6 == 1) op = pick_op();
         step($urandom_range(0, 3) != 0, op);
      end

      // HALT freezes both rings in T4 until reset
      for (int i = 0; i < 30; i++) step(1'b1, 4'd15);
      reset_n = 1'b0;
      reset_model();
      #1;
      check_all();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 4'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Parametrised microprogram sequencer for the SAP CPU, successor to the fixed six-state controller. It runs a T-state ring of configurable length and decodes each T-state and the current opcode into the active-high/active-low mixed control word that drives PC, MAR, RAM, IR, A, ALU, B and OUT. New features:

- optional early termination of short instructions;
- a sticky HALT state;
- a run/step enable;
- an asynchronous active-low reset.

## Interface

Parameters:

- `CW_WIDTH`, 12: control word width. Bits 11..0 are Cp Ep Lm' CE' Li' Ei' La' Ea Su Eu Lb' Lo'. Bits above 11 are always driven 0.
- `OPCODE_WIDTH`, 4: width of `instruction`. Opcodes are compared zero-extended: LDA=0, ADD=1, SUB=2, OUT=14, HALT=15.
- `NUM_T`, 6: number of T-states in the full ring. Must be at least 6. States T7..T`NUM_T` emit NOP.

Ports:

- `clock` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous active-low reset.
- `run` input, 1 bit: when 1, the ring advances each edge; when 0, it holds.
- `instruction` input, `OPCODE_WIDTH` bits: opcode field of the IR.
- `control_word` output, `CW_WIDTH` bits: decoded control word (combinational).
- `t_state` output, `NUM_T` bits: one-hot current T-state. Bit 0 is T1.
- `halted` output, 1 bit: sticky; set by executing HALT.
- `instr_done` output, 1 bit: high during the last T-state of the current instruction.

## Operation

NOP word is 0x3E3 (12'b001111100011), zero-extended to `CW_WIDTH`.

Fetch states, all opcodes:

- T1 = 0x5E3
- T2 = 0xBE3
- T3 = 0x263

Execute states:

- T4:
  - LDA/ADD/SUB = 0x1A3
  - OUT = 0x3F2
  - others = NOP
- T5:
  - LDA = 0x2C3
  - ADD/SUB = 0x2E1
  - others = NOP
- T6:
  - ADD = 0x3C7
  - SUB = 0x3CF
  - others = NOP

Opcode use:

- `instruction` is sampled only in T4 and later. In T3 the IR is still loading, so the opcode is ignored there.
- Undefined opcodes behave as NOP.

Ring advance:

- On an edge with `run`=1 and `halted`=0, the ring goes to T1 if `instr_done`=1; otherwise it goes to the next T-state.
- `instr_done` is high in the last T-state: T`NUM_T`, or the early-end state (see Configuration).

HALT:

- HALT in T4 sets `halted` on the next edge with `run`=1. The ring freezes in T4.
- While halted, `control_word` = NOP, `instr_done`=0, and `t_state` holds T4.
- Only reset clears `halted`.

`run`=0:

- State and `halted` hold.
- `control_word` = NOP and `instr_done`=0, so no register is loaded while stalled.

Reset:

- While `reset_n`=0: ring = T1, `halted`=0, `control_word` = NOP, `t_state` = 1, `instr_done`=0.
- Asserting reset mid-instruction aborts the instruction immediately. This is asynchronous and does not wait for a clock edge.

## Timing

- One state register, updated on the rising edge of `clock`; asynchronous clear on `reset_n`.
- `control_word`, `instr_done` and `t_state` are combinational from state, `halted`, `run`, `reset_n` and `instruction`. No output register, zero latency.
- First cycle after `reset_n` rises: T1 word 0x5E3 is driven, provided `run`=1.
- `run` is sampled at each edge. A low `run` during state Tk causes NOP for that cycle and re-presents Tk in the next cycle.
- Simultaneous `instr_done` and `run`=0: hold; the wrap to T1 happens on the first edge with `run`=1.
- Wrap-around: after T`NUM_T`, the next state is T1. `t_state` is always exactly one-hot.

## Configuration

Macro: `SAP_SEQ_EARLY_END_EN`.

Defined:

- Instruction lengths are LDA=5, ADD/SUB=6, OUT=4, undefined=4.
- `instr_done` is asserted in that state (T5, T6 or T4), or in T`NUM_T` if earlier.
- HALT never asserts `instr_done`.

Undefined:

- Every non-HALT instruction runs all `NUM_T` states.
- `instr_done` is asserted only in T`NUM_T`.

## Test plan

- Default params, early-end defined, `instruction`=LDA, `run`=1 from reset release. Required: `control_word` sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, then 0x5E3. `instr_done` is high only during 0x2C3.
- Early-end undefined, `instruction`=SUB. Required: 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2E1, 0x3CF, then T1. Repeat with OUT: 0x3F2, NOP, NOP, then T1.
- `NUM_T`=8, early-end undefined, ADD. Required: T6 = 0x3C7, T7 and T8 = 0x3E3, `instr_done` high in T8, `t_state` 0x80 wraps to 0x01.
- `instruction`=HALT. Required: at T4, `halted` rises on the next edge. `control_word` stays 0x3E3 and `t_state` stays 0x08 for 20 cycles. Pulsing `reset_n` low returns `t_state`=0x01 and `halted`=0.
- ADD, drop `run` for 3 cycles while in T5. Required: 3 cycles of 0x3E3 with `t_state`=0x10 held, then 0x2E1, then 0x3C7.
- Assert `reset_n`=0 mid-cycle during T5 of LDA. Required: `control_word` = 0x3E3 and `t_state`=0x01 before the next clock edge. After release, the sequence restarts at 0x5E3.
